// File: rtl/differentiator_seq_if.sv
// Sample-stream interface of the sequential comb differentiator.
// master = upstream producer, slave = differentiator.
interface differentiator_seq_if #(
    parameter int word_length = 8
);
    logic [word_length-1:0] data_in;
    logic                   hold;
    logic                   LSB_flag;
    logic [word_length-1:0] data_out;
    logic                   data_valid;

    modport master (
        output data_in,
        output hold,
        output LSB_flag,
        input  data_out,
        input  data_valid
    );

    modport slave (
        input  data_in,
        input  hold,
        input  LSB_flag,
        output data_out,
        output data_valid
    );
endinterface

// File: rtl/differentiator_seq.sv
// Sequential comb differentiator: data_out = data_in - data_in delayed by latency words.
// Optional feature macro DIFF_BORROW_CHAIN_EN enables borrow propagation between sub-words.
module differentiator_seq #(
    parameter int word_length = 8,
    parameter int latency     = 4
) (
    input logic                 clock,
    input logic                 reset_b,
    differentiator_seq_if.slave bus
);
    localparam int CNT_W = $clog2(latency + 1);
    localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(latency);

    logic [word_length-1:0] shft_reg [latency];
    logic [CNT_W-1:0]       fill_cnt;
    logic [word_length-1:0] data_out_q;
    logic                   data_valid_q;
    logic                   accept;
    logic                   borrow_in;
    logic [word_length:0]   sub_full;

    assign accept = !bus.hold;

`ifdef DIFF_BORROW_CHAIN_EN
    logic borrow_reg;

    // The least-significant sub-word starts a fresh subtraction.
    assign borrow_in = bus.LSB_flag ? 1'b0 : borrow_reg;

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            borrow_reg <= 1'b0;
        end else if (accept) begin
            borrow_reg <= sub_full[word_length];
        end
    end
`else
    logic unused_borrow;

    assign borrow_in     = 1'b0;
    assign unused_borrow = ^{bus.LSB_flag, sub_full[word_length]};
`endif

    // Extra MSB of the subtract is the borrow out of this sub-word.
    assign sub_full = {1'b0, bus.data_in}
                    - {1'b0, shft_reg[latency-1]}
                    - {{word_length{1'b0}}, borrow_in};

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < latency; i++) begin
                shft_reg[i] <= '0;
            end
            fill_cnt     <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else if (accept) begin
            shft_reg[0] <= bus.data_in;
            for (int i = 1; i < latency; i++) begin
                shft_reg[i] <= shft_reg[i-1];
            end
            data_out_q   <= sub_full[word_length-1:0];
            data_valid_q <= (fill_cnt == FILL_FULL);
            if (fill_cnt != FILL_FULL) begin
                fill_cnt <= fill_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
endmodule

// File: tb/tb_differentiator_seq.sv
// Directed bench for differentiator_seq: latency-4 instance for ramp/hold/wrap/reset,
// latency-2 instance for the multi-word borrow case.
module tb_differentiator_seq;
    logic clock;
    logic reset_b;
    int   pass_cnt;
    int   total_cnt;

    differentiator_seq_if #(.word_length(8)) bus4 ();
    differentiator_seq_if #(.word_length(8)) bus2 ();

    differentiator_seq #(.word_length(8), .latency(4)) u_dut4 (
        .clock   (clock),
        .reset_b (reset_b),
        .bus     (bus4.slave)
    );

    differentiator_seq #(.word_length(8), .latency(2)) u_dut2 (
        .clock   (clock),
        .reset_b (reset_b),
        .bus     (bus2.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present one word to the latency-4 instance and sample #1 after the edge.
    task automatic step4(input logic [7:0] din, input logic h, input logic lsb);
        bus4.data_in  = din;
        bus4.hold     = h;
        bus4.LSB_flag = lsb;
        @(posedge clock);
        #1;
    endtask

    task automatic step2(input logic [7:0] din, input logic h, input logic lsb);
        bus2.data_in  = din;
        bus2.hold     = h;
        bus2.LSB_flag = lsb;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset_b = 1'b0;
        bus4.data_in = 8'h00; bus4.hold = 1'b1; bus4.LSB_flag = 1'b1;
        bus2.data_in = 8'h00; bus2.hold = 1'b1; bus2.LSB_flag = 1'b1;
        #12;
        total_cnt++;
        if (bus4.data_out !== 8'h00) $display("FAIL reset_out4 got %h exp 00", bus4.data_out);
        else pass_cnt++;
        total_cnt++;
        if (bus4.data_valid !== 1'b0) $display("FAIL reset_valid4 got %b exp 0", bus4.data_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus2.data_out !== 8'h00) $display("FAIL reset_out2 got %h exp 00", bus2.data_out);
        else pass_cnt++;
        total_cnt++;
        if (bus2.data_valid !== 1'b0) $display("FAIL reset_valid2 got %b exp 0", bus2.data_valid);
        else pass_cnt++;
        reset_b = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_ramp;
        logic [7:0] exp_out;
        logic       exp_v;
        for (int k = 1; k <= 8; k++) begin
            step4(8'(k), 1'b0, 1'b1);
            exp_out = (k <= 4) ? 8'(k) : 8'd4;
            exp_v   = (k > 4);
            total_cnt++;
            if (bus4.data_out !== exp_out) $display("FAIL ramp_out[%0d] got %0d exp %0d", k, bus4.data_out, exp_out);
            else pass_cnt++;
            total_cnt++;
            if (bus4.data_valid !== exp_v) $display("FAIL ramp_valid[%0d] got %b exp %b", k, bus4.data_valid, exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold;
        logic [7:0] exp_out;
        for (int k = 9; k <= 11; k++) begin
            step4(8'(k), 1'b1, 1'b1);
            total_cnt++;
            if (bus4.data_out !== 8'd4 || bus4.data_valid !== 1'b1)
                $display("FAIL hold_frozen[%0d] got %0d/%b exp 4/1", k, bus4.data_out, bus4.data_valid);
            else pass_cnt++;
        end
        // Tail at hold was 5; after release 12..15 see tails 5..8, then 16 sees 12.
        for (int k = 12; k <= 16; k++) begin
            step4(8'(k), 1'b0, 1'b1);
            exp_out = (k <= 15) ? 8'd7 : 8'd4;
            total_cnt++;
            if (bus4.data_out !== exp_out || bus4.data_valid !== 1'b1)
                $display("FAIL hold_release[%0d] got %0d/%b exp %0d/1", k, bus4.data_out, bus4.data_valid, exp_out);
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap;
        for (int k = 0; k < 5; k++) step4(8'hF0, 1'b0, 1'b1);
        total_cnt++;
        if (bus4.data_out !== 8'h00) $display("FAIL wrap_const got %h exp 00", bus4.data_out);
        else pass_cnt++;
        step4(8'h10, 1'b0, 1'b1);
        total_cnt++;
        if (bus4.data_out !== 8'h20 || bus4.data_valid !== 1'b1)
            $display("FAIL wrap_out got %h/%b exp 20/1", bus4.data_out, bus4.data_valid);
        else pass_cnt++;
        // hold together with LSB_flag: nothing accepted, output unchanged
        step4(8'h55, 1'b1, 1'b1);
        total_cnt++;
        if (bus4.data_out !== 8'h20) $display("FAIL hold_lsb got %h exp 20", bus4.data_out);
        else pass_cnt++;
    endtask

    task automatic test_borrow;
        logic [7:0] exp_last;
`ifdef DIFF_BORROW_CHAIN_EN
        exp_last = 8'h00;
`else
        exp_last = 8'h01;
`endif
        bus4.hold = 1'b1;
        step2(8'hFF, 1'b0, 1'b1);
        total_cnt++;
        if (bus2.data_out !== 8'hFF || bus2.data_valid !== 1'b0)
            $display("FAIL borrow_w0 got %h/%b exp ff/0", bus2.data_out, bus2.data_valid);
        else pass_cnt++;
        step2(8'h01, 1'b0, 1'b0);
        total_cnt++;
        if (bus2.data_out !== 8'h01 || bus2.data_valid !== 1'b0)
            $display("FAIL borrow_w1 got %h/%b exp 01/0", bus2.data_out, bus2.data_valid);
        else pass_cnt++;
        step2(8'h00, 1'b0, 1'b1);
        total_cnt++;
        if (bus2.data_out !== 8'h01 || bus2.data_valid !== 1'b1)
            $display("FAIL borrow_w2 got %h/%b exp 01/1", bus2.data_out, bus2.data_valid);
        else pass_cnt++;
        step2(8'h02, 1'b0, 1'b0);
        total_cnt++;
        if (bus2.data_out !== exp_last || bus2.data_valid !== 1'b1)
            $display("FAIL borrow_w3 got %h/%b exp %h/1", bus2.data_out, bus2.data_valid, exp_last);
        else pass_cnt++;
        bus2.hold = 1'b1;
    endtask

    task automatic test_reset_midfill;
        reset_b = 1'b0;
        #2;
        reset_b = 1'b1;
        step4(8'h00, 1'b1, 1'b1);
        step4(8'h11, 1'b0, 1'b1);
        step4(8'h22, 1'b0, 1'b1);
        total_cnt++;
        if (bus4.data_out !== 8'h22 || bus4.data_valid !== 1'b0)
            $display("FAIL midfill_pre got %h/%b exp 22/0", bus4.data_out, bus4.data_valid);
        else pass_cnt++;
        bus4.hold = 1'b1;
        #2;
        reset_b = 1'b0;
        #1;
        total_cnt++;
        if (bus4.data_out !== 8'h00 || bus4.data_valid !== 1'b0)
            $display("FAIL midfill_async got %h/%b exp 00/0", bus4.data_out, bus4.data_valid);
        else pass_cnt++;
        #1;
        reset_b = 1'b1;
        step4(8'h00, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step4(8'(8'h30 + k), 1'b0, 1'b1);
            total_cnt++;
            if (bus4.data_out !== 8'(8'h30 + k) || bus4.data_valid !== 1'b0)
                $display("FAIL midfill_refill[%0d] got %h/%b exp %h/0", k, bus4.data_out, bus4.data_valid, 8'(8'h30 + k));
            else pass_cnt++;
        end
        step4(8'h34, 1'b0, 1'b1);
        total_cnt++;
        if (bus4.data_out !== 8'h04 || bus4.data_valid !== 1'b1)
            $display("FAIL midfill_valid got %h/%b exp 04/1", bus4.data_out, bus4.data_valid);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_ramp();
        test_hold();
        test_wrap();
        test_borrow();
        test_reset_midfill();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
